// File: rtl/rr_mux_sequencer.sv
// Round-robin sequencer driving the select of an 8-bit 4:1 mux and forwarding the captured byte on a valid/ready port.
// Optional even-parity output enabled by defining RR_PARITY_EN.
module rr_mux_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [7:0] mux_y,
    output logic [1:0] sel,
    output logic [3:0] ack,
    output logic [7:0] out_data,
    output logic [1:0] out_ch,
    output logic       out_valid,
    input  logic       out_ready
`ifdef RR_PARITY_EN
    ,
    output logic       out_parity
`endif
);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       last;

    // Search last+1, last+2, ... wrapping mod 4; the channel served last has lowest priority.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] idx;
        rr_pick = l;
        for (int k = 4; k >= 1; k--) begin
            idx = l + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 2'd3;
            sel       <= '0;
            ack       <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
`ifdef RR_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel   <= rr_pick(req, last);
                        cnt   <= '0;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Stop counting at the terminal value so cnt stays within range.
                    if (cnt == CNT_LAST) state <= CAPTURE;
                    else                 cnt   <= cnt + 1'b1;
                end
                CAPTURE: begin
                    out_data  <= mux_y;
                    out_ch    <= sel;
                    out_valid <= 1'b1;
                    ack       <= 4'b0001 << sel;
`ifdef RR_PARITY_EN
                    out_parity <= ^mux_y;
`endif
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        last      <= out_ch;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_sequencer.sv
// Self-checking bench for rr_mux_sequencer: directed steps plus randomized transactions
// checked against a transaction-level round-robin model.
module tb_rr_mux_sequencer;

    localparam int SETTLE = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] mux_y;
    logic [1:0] sel;
    logic [3:0] ack;
    logic [7:0] out_data;
    logic [1:0] out_ch;
    logic       out_valid;
    logic       out_ready;
`ifdef RR_PARITY_EN
    logic       out_parity;
`endif

    logic [7:0] data_mem [4];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         model_last = 3;

    assign mux_y = data_mem[sel];

    always #5 clk = ~clk;

    rr_mux_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mux_y     (mux_y),
        .sel       (sel),
        .ack       (ack),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef RR_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: first requesting channel after the last one served, wrapping mod 4.
    function automatic int model_pick(input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (model_last + k) % 4;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic check_cleared(input string tag);
        check({tag, "_sel"}, 32'(sel), 0);
        check({tag, "_ack"}, 32'(ack), 0);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_data"}, 32'(out_data), 0);
        check({tag, "_ch"}, 32'(out_ch), 0);
`ifdef RR_PARITY_EN
        check({tag, "_par"}, 32'(out_parity), 0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        out_ready = 1'b0;
        #2;
        check_cleared("rst");
        tick();
        rst_n = 1'b1;
        model_last = 3;
        tick();
    endtask

    task automatic do_txn(input logic [3:0] r, input int hold_cycles, input bit drop,
                          output int got_ch);
        int         exp_ch;
        int         lat;
        bit         seen;
        logic [7:0] exp_data;
        exp_ch   = model_pick(r);
        exp_data = data_mem[exp_ch];
        got_ch   = -1;
        req = r;
        out_ready = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            tick();
            lat++;
            if (drop && lat == 1) req = '0;
            if (out_valid) seen = 1'b1;
            else check("ack_early", 32'(ack), 0);
        end
        check("latency", 32'(lat), 32'(SETTLE + 2));
        if (!seen) return;
        got_ch = int'(out_ch);
        check("cap_ch", 32'(out_ch), 32'(exp_ch));
        check("cap_data", 32'(out_data), 32'(exp_data));
        check("cap_ack", 32'(ack), 32'(4'b0001 << exp_ch));
        check("cap_sel", 32'(sel), 32'(exp_ch));
`ifdef RR_PARITY_EN
        check("cap_par", 32'(out_parity), 32'(^exp_data));
`endif
        for (int i = 0; i < hold_cycles; i++) begin
            tick();
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", 32'(out_data), 32'(exp_data));
            check("hold_ch", 32'(out_ch), 32'(exp_ch));
            check("hold_ack", 32'(ack), 0);
            check("hold_sel", 32'(sel), 32'(exp_ch));
        end
        out_ready = 1'b1;
        tick();
        check("hs_valid", 32'(out_valid), 0);
        check("hs_ack", 32'(ack), 0);
        out_ready = 1'b0;
        model_last = exp_ch;
    endtask

    initial begin
        int got;
        int order [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) data_mem[i] = 8'(8'h10 + i);

        // Reset held, then idle cycles with no requests.
        do_reset();
        check_cleared("post_rst");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_sel", 32'(sel), 0);
            check("idle_valid", 32'(out_valid), 0);
        end

        // Single request on channel 2, edge-by-edge.
        data_mem[2] = 8'hA5;
        req = 4'b0100;
        out_ready = 1'b1;
        tick();
        check("t2_sel", 32'(sel), 2);
        check("t2_valid1", 32'(out_valid), 0);
        tick();
        check("t2_valid2", 32'(out_valid), 0);
        check("t2_ack2", 32'(ack), 0);
        req = '0;
        tick();
        check("t2_valid3", 32'(out_valid), 1);
        check("t2_data", 32'(out_data), 32'h A5);
        check("t2_ch", 32'(out_ch), 2);
        check("t2_ack", 32'(ack), 32'h4);
        tick();
        check("t2_valid4", 32'(out_valid), 0);
        check("t2_ack4", 32'(ack), 0);
        out_ready = 1'b0;
        model_last = 2;

        // All channels requesting from reset: strict rotation.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_txn(4'b1111, 0, 1'b0, got);
            check("rr_order", 32'(got), 32'(order[i]));
        end
        req = '0;
        tick();

        // Backpressure for 10 cycles.
        data_mem[0] = 8'h3C;
        do_txn(4'b0001, 10, 1'b0, got);
        req = '0;
        tick();

        // Request dropped during settle still completes.
        data_mem[3] = 8'h5A;
        do_txn(4'b1000, 1, 1'b1, got);

        // Async reset while in SETTLE.
        req = 4'b0010;
        tick();
        #2 rst_n = 1'b0;
        #1 check_cleared("rst_settle");
        #2 rst_n = 1'b1;
        req = '0;
        model_last = 3;
        tick();

        // Async reset while in HOLD.
        req = 4'b0100;
        tick();
        tick();
        tick();
        check("pre_rst_hold", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1 check_cleared("rst_hold");
        #2 rst_n = 1'b1;
        req = '0;
        model_last = 3;
        tick();
        do_txn(4'b1111, 0, 1'b0, got);
        check("after_rst_ch0", 32'(got), 0);
        req = '0;

`ifdef RR_PARITY_EN
        data_mem[1] = 8'h07;
        do_txn(4'b0010, 0, 1'b0, got);
        check("par_07", 32'(out_parity), 1);
        data_mem[2] = 8'h03;
        do_txn(4'b0100, 0, 1'b0, got);
        check("par_03", 32'(out_parity), 0);
        req = '0;
`endif

        // Randomized transactions.
        for (int n = 0; n < 30; n++) begin
            logic [3:0] r;
            for (int i = 0; i < 4; i++) data_mem[i] = 8'($urandom);
            r = 4'($urandom_range(1, 15));
            do_txn(r, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got);
            if ($urandom_range(0, 1) == 1) begin
                req = '0;
                tick();
            end
        end
        req = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
